// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU.
// No logic; constants and types only.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter.sv
// Shift/add (MUL) and restoring shift/subtract (DIVU) step datapath, one bit per step.
// acc_nxt is the combinational result of the next step; the caller owns timing and stalls.
module alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     opnd;
  logic [WIDTH+1:0]   addend, sum;
  logic               add_en;

  // mode=1 divides: partial remainder shifted left, B subtracted via A+~B+1.
  // mode=0 multiplies: B added to the high half, then the pair shifts right.
  always_comb begin
    hi      = acc_q[2*WIDTH-1:WIDTH];
    lo      = acc_q[WIDTH-1:0];
    opnd    = mode ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    addend  = mode ? ~{2'b00, b_q} : {2'b00, b_q};
    sum     = {1'b0, opnd} + addend + {{(WIDTH+1){1'b0}}, mode};
    add_en  = mode ? ~sum[WIDTH+1] : lo[0];
    if (mode) begin
      acc_nxt = add_en ? {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1}
                       : {opnd[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = add_en ? {sum[WIDTH:0], lo[WIDTH-1:1]}
                       : {1'b0, hi, lo[WIDTH-1:1]};
    end
    acc_d = acc_q;
    b_d   = b_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a};
      b_d   = b;
    end else if (step) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops finish in 1 cycle, MUL/DIVU in WIDTH+1 cycles.
// start is only accepted in IDLE; requests at other times are dropped, never queued.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] bus,
  input  logic [WIDTH-1:0] y_shifted,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] ALU_out_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic [2*WIDTH-1:0] acc_nxt;
  logic               iter_load, iter_step;

  logic [WIDTH-1:0]   sc_res, sc_hi, b_eff;
  logic [WIDTH:0]     add_sum;
  logic               sc_c, sc_v, sc_err, is_sub;

  logic [WIDTH-1:0]   res, res_hi;
  logic               res_c, res_v, res_err, upd;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_load),
    .step    (iter_step),
    .mode    (state_q == S_DIV),
    .a       (bus),
    .b       (y_shifted),
    .acc_nxt (acc_nxt)
  );

  // Single-cycle datapath straight off the inputs; only registered on acceptance.
  always_comb begin
    is_sub  = (ALU_control == OP_SUB);
    b_eff   = is_sub ? ~y_shifted : y_shifted;
    add_sum = {1'b0, bus} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sc_res  = '0;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_err  = 1'b0;
    case (ALU_control)
      OP_ADD, OP_SUB: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = (bus[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != bus[WIDTH-1]);
      end
      OP_AND: sc_res = bus & y_shifted;
      OP_OR:  sc_res = bus | y_shifted;
      OP_XOR: sc_res = bus ^ y_shifted;
      OP_NOT: sc_res = ~bus;
      OP_SHL: begin
        sc_res = {bus[WIDTH-2:0], 1'b0};
        sc_c   = bus[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, bus[WIDTH-1:1]};
        sc_c   = bus[0];
      end
      OP_DIVU: begin
        // Only reached here with a zero divisor.
        sc_res = '1;
        sc_hi  = bus;
        sc_err = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    upd       = 1'b0;
    res       = sc_res;
    res_hi    = sc_hi;
    res_c     = sc_c;
    res_v     = sc_v;
    res_err   = sc_err;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (ALU_control == OP_MUL) begin
            state_d   = S_MUL;
            iter_load = 1'b1;
          end else if (ALU_control == OP_DIVU && y_shifted != '0) begin
            state_d   = S_DIV;
            iter_load = 1'b1;
          end else begin
            state_d = S_DONE;
            upd     = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          upd     = 1'b1;
          res     = acc_nxt[WIDTH-1:0];
          res_hi  = acc_nxt[2*WIDTH-1:WIDTH];
          res_c   = (state_q == S_MUL) && (res_hi != '0);
          res_v   = res_c;
          res_err = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_d   = out_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    err_d   = err_q;
    if (upd) begin
      out_d           = res;
      hi_d            = res_hi;
      err_d           = res_err;
      flags_d[FLAG_N] = res[WIDTH-1];
      flags_d[FLAG_Z] = (res == '0);
      flags_d[FLAG_C] = res_c;
      flags_d[FLAG_V] = res_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
  assign done       = (state_q == S_DONE);
  assign ALU_out    = out_q;
  assign ALU_out_hi = hi_q;
  assign flags      = flags_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_ctl = 4'd0;
  logic [W-1:0] bus = '0;
  logic [W-1:0] y_shifted = '0;
  logic         busy, done, err;
  logic [W-1:0] alu_out, alu_out_hi;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ALU_control (alu_ctl),
    .bus         (bus),
    .y_shifted   (y_shifted),
    .busy        (busy),
    .done        (done),
    .ALU_out     (alu_out),
    .ALU_out_hi  (alu_out_hi),
    .flags       (flags),
    .err         (err)
  );

  // Accept at edge 0; returns sampling in the middle of cycle 1.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    alu_ctl   = op;
    bus       = a;
    y_shifted = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Advances from cycle first until done is seen (bounded); counts busy cycles on the way.
  task automatic wait_done(input int first, output int cyc, output int busy_cnt);
    cyc      = first;
    busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, alu_out, alu_out_hi, flags, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h hi=%h flags=%b err=%b, want all 0",
               busy, done, alu_out, alu_out_hi, flags, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    issue(4'd0, 16'h5555, 16'hAAAA);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL add_timing: done=%b busy=%b, want 1/0", done, busy);
    end
    checks++;
    if ({alu_out, alu_out_hi, flags, err} !== {16'hFFFF, 16'h0000, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL add_result: out=%h hi=%h flags=%b err=%b, want ffff 0000 1000 0",
                         alu_out, alu_out_hi, flags, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b in cycle 2, want 0", done);
    end
    issue(4'd0, 16'hFFFF, 16'h0001);
    checks++;
    if ({alu_out, flags} !== {16'h0000, 4'b0110}) begin
      errors++; $display("FAIL add_carry: out=%h flags=%b, want 0000 0110", alu_out, flags);
    end
  endtask

  task automatic test_sub_shift;
    issue(4'd1, 16'h8000, 16'h0001);
    checks++;
    if ({alu_out, flags, err} !== {16'h7FFF, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL sub_ovf: out=%h flags=%b err=%b, want 7fff 0011 0", alu_out, flags, err);
    end
    issue(4'd6, 16'h8001, 16'h0000);
    checks++;
    if ({alu_out, flags} !== {16'h0002, 4'b0010}) begin
      errors++; $display("FAIL shl: out=%h flags=%b, want 0002 0010", alu_out, flags);
    end
    issue(4'd7, 16'h0003, 16'h0000);
    checks++;
    if ({alu_out, flags} !== {16'h0001, 4'b0010}) begin
      errors++; $display("FAIL shr: out=%h flags=%b, want 0001 0010", alu_out, flags);
    end
    issue(4'd5, 16'h00FF, 16'h1234);
    checks++;
    if ({alu_out, alu_out_hi, flags} !== {16'hFF00, 16'h0000, 4'b1000}) begin
      errors++; $display("FAIL not: out=%h hi=%h flags=%b, want ff00 0000 1000", alu_out, alu_out_hi, flags);
    end
  endtask

  task automatic test_mul;
    int cyc, bc;
    issue(4'd8, 16'h1234, 16'h0100);
    // Operands must already be latched.
    bus = 16'hDEAD; y_shifted = 16'hBEEF; alu_ctl = 4'd1;
    wait_done(1, cyc, bc);
    checks++;
    if (cyc !== 17 || bc !== 16 || busy !== 1'b0) begin
      errors++; $display("FAIL mul_timing: done cycle=%0d busy cycles=%0d busy_at_done=%b, want 17 16 0",
                         cyc, bc, busy);
    end
    checks++;
    if ({alu_out, alu_out_hi, flags, err} !== {16'h3400, 16'h0012, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL mul_1234: out=%h hi=%h flags=%b err=%b, want 3400 0012 0011 0",
                         alu_out, alu_out_hi, flags, err);
    end
    issue(4'd8, 16'hFFFF, 16'hFFFF);
    wait_done(1, cyc, bc);
    checks++;
    if ({alu_out, alu_out_hi, flags} !== {16'h0001, 16'hFFFE, 4'b0011}) begin
      errors++; $display("FAIL mul_ffff: out=%h hi=%h flags=%b, want 0001 fffe 0011", alu_out, alu_out_hi, flags);
    end
  endtask

  task automatic test_div;
    int cyc, bc;
    issue(4'd12, 16'h1111, 16'h2222);
    issue(4'd9, 16'd100, 16'd7);
    wait_done(1, cyc, bc);
    checks++;
    if (cyc !== 17 || bc !== 16) begin
      errors++; $display("FAIL div_timing: done cycle=%0d busy cycles=%0d, want 17 16", cyc, bc);
    end
    checks++;
    if ({alu_out, alu_out_hi, flags, err} !== {16'd14, 16'd2, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL div_100_7: q=%0d r=%0d flags=%b err=%b, want 14 2 0000 0",
                         alu_out, alu_out_hi, flags, err);
    end
    issue(4'd9, 16'h1234, 16'h0000);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL div0_timing: done=%b busy=%b, want 1/0", done, busy);
    end
    checks++;
    if ({alu_out, alu_out_hi, flags, err} !== {16'hFFFF, 16'h1234, 4'b1000, 1'b1}) begin
      errors++; $display("FAIL div0_result: out=%h hi=%h flags=%b err=%b, want ffff 1234 1000 1",
                         alu_out, alu_out_hi, flags, err);
    end
  endtask

  task automatic test_ignore_start;
    int cyc, bc;
    issue(4'd8, 16'h1234, 16'h0100);
    repeat (3) @(negedge clk);
    alu_ctl = 4'd0; bus = 16'h0001; y_shifted = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc, bc);
    checks++;
    if (cyc !== 17 || {alu_out, alu_out_hi} !== {16'h3400, 16'h0012}) begin
      errors++; $display("FAIL mul_ignore_start: cycle=%0d out=%h hi=%h, want 17 3400 0012",
                         cyc, alu_out, alu_out_hi);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, alu_out} !== {2'b00, 16'h3400}) begin
      errors++; $display("FAIL no_queue: done=%b busy=%b out=%h, want 0 0 3400", done, busy, alu_out);
    end
  endtask

  task automatic test_reset_mid;
    issue(4'd8, 16'h1234, 16'h0100);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, alu_out, alu_out_hi, flags, err} !== '0) begin
      errors++; $display("FAIL reset_mid_mul: busy=%b done=%b out=%h hi=%h flags=%b err=%b, want all 0",
                         busy, done, alu_out, alu_out_hi, flags, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 16'h0001, 16'h0002);
    checks++;
    if ({done, busy, alu_out, flags} !== {2'b10, 16'h0003, 4'b0000}) begin
      errors++; $display("FAIL add_after_reset: done=%b busy=%b out=%h flags=%b, want 1 0 0003 0000",
                         done, busy, alu_out, flags);
    end
  endtask

  task automatic test_reserved;
    issue(4'hC, 16'hABCD, 16'h1234);
    checks++;
    if ({alu_out, alu_out_hi, flags, err} !== {16'h0000, 16'h0000, 4'b0100, 1'b1}) begin
      errors++; $display("FAIL reserved_op: out=%h hi=%h flags=%b err=%b, want 0000 0000 0100 1",
                         alu_out, alu_out_hi, flags, err);
    end
    issue(4'd2, 16'h0F0F, 16'h00FF);
    checks++;
    if ({alu_out, flags, err} !== {16'h000F, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL and_clears_err: out=%h flags=%b err=%b, want 000f 0000 0", alu_out, flags, err);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    alu_ctl = 4'd0; bus = 16'h0001; y_shifted = 16'h0001; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, alu_out} !== {1'b1, 16'h0002}) begin
      errors++; $display("FAIL b2b_first: done=%b out=%h, want 1 0002", done, alu_out);
    end
    bus = 16'h0005; y_shifted = 16'h0005;
    @(negedge clk);
    checks++;
    if ({done, alu_out} !== {1'b0, 16'h0002}) begin
      errors++; $display("FAIL b2b_gap: done=%b out=%h, want 0 0002", done, alu_out);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, alu_out} !== {1'b1, 16'h000A}) begin
      errors++; $display("FAIL b2b_second: done=%b out=%h, want 1 000a", done, alu_out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_mul();
    test_div();
    test_ignore_start();
    test_reset_mid();
    test_reserved();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
